pulse_stretcher: RTL and testbench

- Output-side conditioner, the counterpart to input debouncing.
- Takes short internal event strobes (FSM done flags, debounced button edges) and drives a clean external/LED pulse.
- Each pulse has a guaranteed minimum high time and a minimum low time, so a human or a slow external device can see each event.
- Queues one extra event arriving while busy and flags any events beyond that.

---
 rtl/pulse_stretcher.sv | 130 +++++++++++++
 tb/tb_pulse_stretcher.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches short event strobes into pulses with guaranteed min high/low times; queues one extra event.
// Optional: define PULSE_STRETCHER_RETRIGGER_EN so events during the high phase restart it.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int CNT_W       = $clog2((HOLD_CYCLES > GAP_CYCLES)
                                     ? ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2)
                                     : ((GAP_CYCLES > 2) ? GAP_CYCLES : 2))
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic en,
  output logic pulse_out,
  output logic busy,
  output logic done,
  output logic drop
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q;
  logic             pending_q, pending_d;
  logic             pulse_q, busy_q, done_q, drop_q;
  logic             done_d, drop_d;
  logic             ev;
  logic             queue_ev;
  logic             gap_last;

  assign ev       = trig & ~trig_q & en;
  assign queue_ev = ev & ((state_q == GAP) | ((state_q == ACTIVE) & ~RETRIG));
  // With no gap configured, GAP is only entered to serve a pending event and lasts one cycle.
  assign gap_last = (GAP_CYCLES == 0) || (cnt_q == GAP_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;

    if (queue_ev) begin
      if (pending_q) drop_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (RETRIG && ev) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (GAP_CYCLES > 0 || pending_q || ev) state_d = GAP;
          else                                   state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          cnt_d = '0;
          // An event landing in the final gap cycle is served here rather than lost.
          if (pending_q || ev) begin
            state_d   = ACTIVE;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      pending_q <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trig_q    <= trig;
      pending_q <= pending_d;
      pulse_q   <= (state_d == ACTIVE);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HOLD_CYCLES=4, GAP_CYCLES=2; outputs checked as {pulse_out,busy,done,drop}.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trig = 1'b0;
  logic en = 1'b1;
  logic pulse_out, busy, done, drop;

  int n_checks = 0;
  int n_pass   = 0;

  pulse_stretcher #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig),
    .en       (en),
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s pbdx=%b", tag, got);
    end else begin
      $display("FAIL %-14s got pbdx=%b expected %b", tag, got, exp);
    end
  endtask

  // Drive trig, let one posedge sample it, then check outputs 1 time unit later.
  task automatic cyc(input string tag, input logic t, input logic [3:0] exp);
    trig = t;
    @(posedge clk);
    #1;
    check(tag, {pulse_out, busy, done, drop}, exp);
  endtask

  task automatic run_seq(input string name, input logic [31:0] trig_v,
                         input logic [3:0] exp_v [], input int n);
    for (int i = 0; i < n; i++)
      cyc($sformatf("%s_t%0d", name, i), trig_v[i], exp_v[i]);
  endtask

  logic [3:0] ev_single [] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0100,
                               4'b0000, 4'b0000};
`ifdef PULSE_STRETCHER_RETRIGGER_EN
  logic [3:0] ev_second [] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
                               4'b0110, 4'b0100, 4'b0000, 4'b0000};
`else
  logic [3:0] ev_second [] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0100,
                               4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0100,
                               4'b0000};
  logic [3:0] ev_over [] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0111, 4'b0100,
                             4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0100,
                             4'b0000, 4'b0000};
`endif

  initial begin
    // Reset state while rst is low
    #12;
    check("reset", {pulse_out, busy, done, drop}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    cyc("idle", 1'b0, 4'b0000);

    // Single event; trig held high afterwards must not retrigger
    run_seq("single", 32'h0000_00FF, ev_single, 8);
    cyc("single_lo", 1'b0, 4'b0000);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    // Second edge at t2 extends one pulse to 6 cycles
    run_seq("retrig", 32'h0000_0005, ev_second, 10);
`else
    // Second edge at t2 is queued and served after the gap
    run_seq("pend", 32'h0000_000D, ev_second, 13);
    // Edges at t0, t2, t4: third is dropped at the end of the high phase
    run_seq("over", 32'h0000_0015, ev_over, 14);
`endif

    // en gating: edge ignored while en=0, and a still-high trig does not fire later
    en = 1'b0;
    cyc("en0_a", 1'b0, 4'b0000);
    cyc("en0_b", 1'b1, 4'b0000);
    cyc("en0_c", 1'b1, 4'b0000);
    en = 1'b1;
    cyc("en1_hi_a", 1'b1, 4'b0000);
    cyc("en1_hi_b", 1'b1, 4'b0000);
    cyc("en1_fall", 1'b0, 4'b0000);
    run_seq("en1_rise", 32'h0000_00FF, ev_single, 7);
    cyc("en1_end", 1'b0, 4'b0000);

    // Reset mid-pulse with a pending event
    cyc("rm_t0", 1'b1, 4'b1100);
    cyc("rm_t1", 1'b0, 4'b1100);
    cyc("rm_t2", 1'b1, 4'b1100);
    #2;
    rst = 1'b0;
    #1;
    check("rm_async", {pulse_out, busy, done, drop}, 4'b0000);
    trig = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++)
      cyc($sformatf("rm_after%0d", i), 1'b0, 4'b0000);

    // trig held high across reset release counts as one event
    rst = 1'b0;
    trig = 1'b1;
    @(posedge clk);
    #1;
    check("rh_in_reset", {pulse_out, busy, done, drop}, 4'b0000);
    rst = 1'b1;
    run_seq("rh", 32'h0000_00FF, ev_single, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
